// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI LED command slave.
// Frames are 8 bits LSB first: bit 0 selects the bank, bits 7:1 carry the pattern.
package spi_pkg;

  localparam int FRAME_BITS    = 8;
  localparam int LED_COUNT     = FRAME_BITS - 1;
  localparam int CNT_W         = $clog2(FRAME_BITS);

  localparam int CMD_COLOR_BIT = 0;
  localparam int CMD_LED_MSB   = 7;
  localparam int CMD_LED_LSB   = 1;

  localparam logic COLOR_RED   = 1'b0;
  localparam logic COLOR_BLUE  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WAIT_CS_HIGH
  } state_e;

endpackage

// File: rtl/led_cmd_decode.sv
// Registered red/blue LED banks, loaded from a completed command byte on a strobe.
// Only the bank selected by the colour bit changes; the other bank holds.
module led_cmd_decode
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] cmd_byte,
  output logic [LED_COUNT-1:0]  red_leds,
  output logic [LED_COUNT-1:0]  blue_leds
);

  logic [LED_COUNT-1:0] red_q, red_d;
  logic [LED_COUNT-1:0] blue_q, blue_d;

  always_comb begin
    red_d  = red_q;
    blue_d = blue_q;
    if (load) begin
      if (cmd_byte[CMD_COLOR_BIT] == COLOR_BLUE) begin
        blue_d = cmd_byte[CMD_LED_MSB:CMD_LED_LSB];
      end else begin
        red_d  = cmd_byte[CMD_LED_MSB:CMD_LED_LSB];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_q  <= '0;
      blue_q <= '0;
    end else begin
      red_q  <= red_d;
      blue_q <= blue_d;
    end
  end

  assign red_leds  = red_q;
  assign blue_leds = blue_q;

endmodule

// File: rtl/spi_led_slave.sv
// SPI mode-1 slave: shifts in LSB-first LED command frames, echoes the previous
// frame on MISO, and reports completions, aborts and a running frame count.
module spi_led_slave
  import spi_pkg::*;
#(
  parameter logic [FRAME_BITS-1:0] RESET_REPLY = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chipSelect,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic [LED_COUNT-1:0]  redLeds,
  output logic [LED_COUNT-1:0]  blueLeds,
  output logic [FRAME_BITS-1:0] rxByte,
  output logic                  rxValid,
  output logic                  frameAbort,
  output logic [7:0]            frameCount
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [FRAME_BITS-1:0] rx_byte_q, rx_byte_d;
  logic [FRAME_BITS-1:0] tx_reg_q, tx_reg_d;
  logic [7:0]            frame_count_q, frame_count_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_abort_q, frame_abort_d;
  logic [FRAME_BITS-1:0] shifted;

  assign shifted = {MOSI, rx_shift_q[FRAME_BITS-1:1]};

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    rx_byte_d     = rx_byte_q;
    tx_reg_d      = tx_reg_q;
    frame_count_d = frame_count_q;
    rx_valid_d    = 1'b0;
    frame_abort_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!chipSelect) begin
          rx_shift_d = shifted;
          bit_cnt_d  = CNT_W'(1);
          state_d    = RECV;
        end
      end
      RECV: begin
        if (chipSelect) begin
          rx_shift_d    = '0;
          bit_cnt_d     = '0;
          frame_abort_d = 1'b1;
          state_d       = IDLE;
        end else if (bit_cnt_q == LAST_BIT) begin
          rx_shift_d    = shifted;
          rx_byte_d     = shifted;
          tx_reg_d      = shifted;
          rx_valid_d    = 1'b1;
          frame_count_d = frame_count_q + 8'd1;
          bit_cnt_d     = '0;
          state_d       = WAIT_CS_HIGH;
        end else begin
          rx_shift_d = shifted;
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
        end
      end
      WAIT_CS_HIGH: begin
        if (chipSelect) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      rx_byte_q     <= '0;
      tx_reg_q      <= RESET_REPLY;
      frame_count_q <= '0;
      rx_valid_q    <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      rx_byte_q     <= rx_byte_d;
      tx_reg_q      <= tx_reg_d;
      frame_count_q <= frame_count_d;
      rx_valid_q    <= rx_valid_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  // LED banks load on the same edge that takes the 8th sample.
  led_cmd_decode u_led_cmd_decode (
    .clk       (clk),
    .rst_n     (rst),
    .load      (rx_valid_d),
    .cmd_byte  (rx_byte_d),
    .red_leds  (redLeds),
    .blue_leds (blueLeds)
  );

  // Reset gates MISO so it reads 0 even if the reply register is nonzero.
  assign MISO = rst && !chipSelect && ((state_q == IDLE) || (state_q == RECV))
                && tx_reg_q[bit_cnt_q];

  assign rxByte     = rx_byte_q;
  assign rxValid    = rx_valid_q;
  assign frameAbort = frame_abort_q;
  assign frameCount = frame_count_q;

endmodule

// File: doc/spi_led_slave.md
# spi_led_slave

SPI mode-1 slave that receives the 8-bit LED command frames produced by the SPI master model and drives the red and blue LED banks. It sits directly downstream of the master on the shared `chipSelect`/`MOSI`/`MISO` link. It returns the previously received byte on `MISO` as an echo/status. It also reports completed frames, aborted frames and a running frame count to the surrounding test/debug logic.

## Interface
- `FRAME_BITS`, 8: bits per frame; fixed at 8, LSB first.
- `LED_COUNT`, 7: LEDs per bank; equals `FRAME_BITS-1`.
- `RESET_REPLY`, 8'h00: echo register value after reset.
- `clk`  in  1  system/SPI clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `chipSelect`  in  1  active-low frame select from master.
- `MOSI`  in  1  serial data from master, LSB first.
- `MISO`  out  1  serial echo to master, LSB first.
- `redLeds`  out  7  red bank pattern.
- `blueLeds`  out  7  blue bank pattern.
- `rxByte`  out  8  last completed frame.
- `rxValid`  out  1  one-cycle pulse per completed frame.
- `frameAbort`  out  1  one-cycle pulse when a frame is cut short.
- `frameCount`  out  8  completed-frame counter.

## Operation
- Master contract: `MOSI` holds bit k for one full cycle while `chipSelect`=0. The master samples `MISO` on the falling edge inside that cycle.
- FSM states: IDLE, RECV, WAIT_CS_HIGH.
- IDLE, `chipSelect`=0 at a rising edge:
  - sample `MOSI` into `rxShift` as `{MOSI, rxShift[7:1]}`;
  - `bitCnt`<=1;
  - go to RECV.
- RECV, `chipSelect`=0, `bitCnt`<7: shift as above, increment `bitCnt`.
- RECV, `chipSelect`=0, `bitCnt`=7 (8th sample): complete the frame.
  - `rxByte` <= `{MOSI, rxShift[7:1]}`, `rxValid`<=1 for one cycle.
  - `txReg` <= completed byte.
  - `frameCount`++, wrapping 255 -> 0.
  - LED decode, same edge.
  - `bitCnt`<=0, go to WAIT_CS_HIGH.
- RECV, `chipSelect`=1 (`bitCnt` 1..7): abort the frame.
  - discard partial bits, `bitCnt`<=0;
  - `frameAbort`<=1 for one cycle;
  - LEDs, `rxByte`, `txReg` and `frameCount` unchanged;
  - go to IDLE.
- WAIT_CS_HIGH: extra bits are ignored and `MISO`=0. `chipSelect`=1 -> IDLE. No abort is flagged.
- LED decode of completed byte `b`:
  - `b[0]`=0 -> `redLeds`<=`b[7:1]`;
  - `b[0]`=1 -> `blueLeds`<=`b[7:1]`;
  - the other bank holds its value.
- `MISO`, combinational:
  - `txReg[bitCnt]` while `chipSelect`=0 in IDLE or RECV;
  - 0 otherwise.
  - No tristate.
- Echo timing: the byte received in frame N is returned during frame N+1.

## Timing
- Reset (`rst`=0) forces, asynchronously:
  - state IDLE, `bitCnt`=0;
  - `rxShift`=0, `rxByte`=0;
  - `txReg`=`RESET_REPLY`;
  - `redLeds`=0, `blueLeds`=0;
  - `rxValid`=0, `frameAbort`=0;
  - `frameCount`=0, `MISO`=0.
- Reset mid-frame: partial frame lost, no pulse emitted. A frame starts cleanly at the first rising edge with `chipSelect`=0 after release.
- Latency: `rxValid`, `rxByte`, LEDs and `frameCount` update on the rising edge that takes the 8th sample, so they are visible in the following cycle.
- `MISO` bit k is valid for the whole cycle in which the master presents `MOSI` bit k, so it is stable at the master's falling-edge sample.
- Back-to-back frames: `chipSelect` high for at least 1 cycle between frames is sufficient. Completion and the first sample of the next frame never coincide.
- `rxValid` and `frameAbort` are mutually exclusive.
- Holding `chipSelect` low across more than 8 cycles yields exactly one frame.

## Structure
- Shared package `spi_pkg` holds:
  - state encoding (IDLE/RECV/WAIT_CS_HIGH);
  - `FRAME_BITS`;
  - command field constants: `CMD_COLOR_BIT`=0, `CMD_LED_MSB`=7, `CMD_LED_LSB`=1;
  - `COLOR_RED`=0, `COLOR_BLUE`=1.
- One sub-module, `led_cmd_decode`: registered LED banks, loaded on a completion strobe with the completed byte. The FSM, shifter and counters stay in the top level.

## Test plan
- Send the 16-frame master sequence 0x02,0x04,...,0x80,0x00,0x03,0x05,...,0x81,0x01. Required response:
  - `redLeds` steps 0x01,0x02,...,0x40 then 0x00;
  - `blueLeds` steps the same way through 0x01..0x40 then 0x00;
  - 16 `rxValid` pulses, `frameCount`=16.
- Echo check:
  - frame 0x02 then 0x04 -> master receives 0x00 (`RESET_REPLY`) during the first frame and 0x02 during the second;
  - with `RESET_REPLY`=8'hA5 the first reply is 0xA5.
- Abort: raise `chipSelect` after 5 bits of 0x7E -> `frameAbort` pulses once, no `rxValid`, LEDs and `frameCount` unchanged. The next full frame 0x08 gives `redLeds`=0x04.
- Wrap: 256 frames of 0x00 -> `frameCount` returns to 0, `redLeds`=0.
- Overlong select: hold `chipSelect` low for 12 cycles with 0x41 then 4 ones -> exactly one `rxValid`, `blueLeds`=0x20, `MISO`=0 for the last 4 cycles.
- Reset mid-frame: assert `rst`=0 after 3 bits -> all outputs 0 immediately. After release, frame 0x80 gives `redLeds`=0x40 and `frameCount`=1.
